mips_perf_monitor: RTL and testbench
====================================

Name: mips_perf_monitor

Overview:
- Parametrised run-control and performance/trace monitor attached to the debug outputs of the pipelined MIPS core.
- Replaces fixed-delay simulation termination and the free-running 7-bit cycle counter.
- Provides a run state machine with cycle limit and halt detection, saturating event counters, and a register-writeback trace FIFO with a valid/ready drain port.
- Synthesisable; used both in benches and in on-board debug.

Parameters:
- CNT_W, 32: width of every event counter.
- MAX_CYCLES, 1000: RUN-cycle limit before forced DONE. 0 means no limit.
- TRACE_DEPTH, 8: trace FIFO entries. Power of 2, minimum 2.
- HALT_REPEAT, 4: consecutive unstalled cycles with unchanged PC that declare a halt. Minimum 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  IDLE->RUN request
- clear  in  1  synchronous clear of counters, FIFO and overflow; returns the FSM to IDLE
- PC  in  10  core fetch PC
- Instruction_in  in  32  core instruction in decode
- stall_in  in  1  core stall
- Branch_in  in  1  branch in EX
- Zero_in  in  1  ALU zero
- MemWrite_in  in  1  store in MEM
- RegWrite_in  in  1  writeback enable
- dest_in  in  5  writeback register
- write_data_in  in  32  writeback data
- state_out  out  2  FSM state
- done  out  1  high in DONE
- halted  out  1  sticky; DONE was reached by halt detection
- cycle_cnt  out  CNT_W  RUN cycles
- instr_cnt  out  CNT_W  issued non-NOP instructions
- stall_cnt  out  CNT_W  stalled cycles
- branch_taken_cnt  out  CNT_W  taken branches
- mem_write_cnt  out  CNT_W  stores
- trace_valid  out  1  FIFO non-empty
- trace_data  out  37  {dest[4:0], data[31:0]} at FIFO head
- trace_ready  in  1  consumer accepts head
- trace_level  out  $clog2(TRACE_DEPTH)+1  FIFO occupancy
- trace_overflow  out  1  sticky; a push was dropped

Behaviour:
- Reset (async):
  - state IDLE; all counters 0; FIFO empty.
  - trace_valid, trace_overflow, halted and done are 0; trace_data is 0.
- States: IDLE=0, RUN=1, DONE=2. Encoding 3 is illegal and goes to IDLE next cycle.
- IDLE:
  - Counters hold.
  - start=1 moves to RUN next edge. Counting begins on the first RUN cycle.
- RUN, every cycle:
  - cycle_cnt +1.
  - stall_cnt +1 if stall_in.
  - instr_cnt +1 if !stall_in and Instruction_in != 0.
  - branch_taken_cnt +1 if Branch_in & Zero_in.
  - mem_write_cnt +1 if MemWrite_in.
- Counters saturate at all-ones and never wrap.
- RUN->DONE on the edge where cycle_cnt becomes MAX_CYCLES (only if MAX_CYCLES != 0).
- Halt detection:
  - A halt counter counts consecutive RUN cycles with !stall_in and PC equal to the previous cycle's PC.
  - A stall or a PC change resets it to 0.
  - When it reaches HALT_REPEAT-1, the FSM goes RUN->DONE and halted is set.
  - If the cycle limit and the halt fire on the same edge, DONE is entered and halted=1.
- DONE:
  - Counters freeze; done=1.
  - start is ignored. Only clear or reset leaves DONE.
- clear:
  - Takes priority over start and all FSM transitions.
  - Next edge: state IDLE, counters 0, FIFO flushed, sticky flags 0.
- Trace FIFO:
  - Push when state==RUN, RegWrite_in=1 and dest_in != 0.
  - Pop when trace_valid & trace_ready.
  - First-word fall-through: a pushed entry appears on trace_data the cycle after the push edge.
  - Full with push and no pop: entry dropped, trace_overflow set.
  - Full with push and pop on the same edge: both execute, no overflow.
  - Empty with push and pop on the same edge: pop ignored (trace_valid=0); push executes.
  - Empty: trace_valid=0; trace_data holds its last value.
  - Pops remain legal in IDLE and DONE, so the FIFO drains after the run.
- Pointers wrap modulo TRACE_DEPTH. trace_level equals pushes minus pops.

Decomposition:
- Package mips_mon_pkg holds:
  - mon_state_t enum (IDLE, RUN, DONE).
  - trace_entry_t packed struct (dest[4:0], data[31:0]).
  - TRACE_W=37 constant.
- Sub-module mips_trace_fifo: synchronous FIFO parametrised by depth and entry type, with push/pop/full/empty/level and async reset.
- Counters and FSM stay in the top module.

Test Plan:
- Reset then start=1 for one cycle; stimulus 10 cycles of unstalled, changing PC, nonzero instructions, with stall_in=1 on cycles 3-4 -> cycle_cnt=10, stall_cnt=2, instr_cnt=8, state RUN.
- MAX_CYCLES=16, PC incrementing, no stalls -> done=1 exactly 16 edges after entering RUN; halted=0; cycle_cnt frozen at 16 for 5 further cycles.
- PC held at 0x024 with stall_in=0, HALT_REPEAT=4 -> DONE on 3rd repeat cycle; halted=1; a start pulse in DONE has no effect; clear returns to IDLE with all counters 0.
- trace_ready=0, 9 writebacks to $1..$9 with data 0x100+n, TRACE_DEPTH=8 -> trace_level=8, trace_overflow=1; draining yields dest 1..8 in order; a write to $0 is never pushed.
- FIFO full, simultaneous push (dest 5, data 0xDEAD) and pop -> level stays 8, overflow stays 0, and 0xDEAD is the last entry drained.
- CNT_W=4, stall_in=1 for 20 RUN cycles -> stall_cnt saturates at 15; async reset asserted mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_mon_pkg.sv
// Shared types for the MIPS run-control / performance monitor.
package mips_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } trace_entry_t;

    localparam int unsigned TRACE_W = 37;

endpackage

// File: rtl/mips_perf_monitor_if.sv
// Register-writeback trace drain port: the monitor drives, the consumer accepts.
interface mips_perf_monitor_if
    import mips_mon_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 8
);
    logic                         trace_valid;
    trace_entry_t                 trace_data;
    logic                         trace_ready;
    logic [$clog2(TRACE_DEPTH):0] trace_level;
    logic                         trace_overflow;

    modport master (
        output trace_valid,
        output trace_data,
        output trace_level,
        output trace_overflow,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_data,
        input  trace_level,
        input  trace_overflow,
        output trace_ready
    );

endinterface

// File: rtl/mips_trace_fifo.sv
// First-word fall-through FIFO; while empty the output keeps showing the last head value.
module mips_trace_fifo
    import mips_mon_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = logic [TRACE_W-1:0]
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  entry_t                 i_data,
    output entry_t                 o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE  = 1;

    entry_t      r_mem [DEPTH];
    entry_t      r_last;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer bit distinguishes full from empty.
    always_comb begin
        o_level   = r_wr_ptr - r_rd_ptr;
        o_empty   = (r_wr_ptr == r_rd_ptr);
        o_full    = (o_level == FULL_LVL);
        w_do_pop  = i_pop && !o_empty;
        w_do_push = i_push && (!o_full || w_do_pop);
        o_data    = o_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            r_last <= o_data;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/mips_perf_monitor.sv
// Run-control FSM, saturating event counters and writeback trace for the pipelined MIPS core.
module mips_perf_monitor
    import mips_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [9:0]       PC,
    input  logic [31:0]      Instruction_in,
    input  logic             stall_in,
    input  logic             Branch_in,
    input  logic             Zero_in,
    input  logic             MemWrite_in,
    input  logic             RegWrite_in,
    input  logic [4:0]       dest_in,
    input  logic [31:0]      write_data_in,
    output logic [1:0]       state_out,
    output logic             done,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] branch_taken_cnt,
    output logic [CNT_W-1:0] mem_write_cnt,
    mips_perf_monitor_if.master trace
);
    localparam int unsigned       LVL_W     = $clog2(TRACE_DEPTH) + 1;
    localparam int unsigned       HALT_W    = $clog2(HALT_REPEAT) + 1;
    localparam logic [HALT_W-1:0] HALT_LAST = HALT_W'(HALT_REPEAT - 1);
    localparam logic [63:0]       MAX_CYC   = 64'(MAX_CYCLES);

    mon_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cycle, r_instr, r_stall, r_branch, r_memw;
    logic [CNT_W-1:0]  w_cycle_nxt, w_instr_nxt, w_stall_nxt, w_branch_nxt, w_memw_nxt;
    logic [HALT_W-1:0] r_halt_cnt, w_halt_nxt;
    logic [9:0]        r_prev_pc;
    logic              r_halted, r_overflow;
    logic              w_run, w_repeat, w_limit_hit, w_halt_hit;
    logic              w_push, w_pop, w_full, w_empty;
    trace_entry_t      w_push_entry, w_head;
    logic [LVL_W-1:0]  w_level;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        w_run        = (r_state == RUN);
        w_repeat     = !stall_in && (PC == r_prev_pc);
        w_cycle_nxt  = sat_inc(r_cycle, 1'b1);
        w_stall_nxt  = sat_inc(r_stall, stall_in);
        w_instr_nxt  = sat_inc(r_instr, !stall_in && (Instruction_in != '0));
        w_branch_nxt = sat_inc(r_branch, Branch_in && Zero_in);
        w_memw_nxt   = sat_inc(r_memw, MemWrite_in);
        w_halt_nxt   = w_repeat ? r_halt_cnt + HALT_W'(1) : '0;
        // Saturated value can only equal the limit if the limit was reached first.
        w_limit_hit  = w_run && (MAX_CYCLES != 0) && (64'(w_cycle_nxt) == MAX_CYC);
        w_halt_hit   = w_run && w_repeat && (w_halt_nxt == HALT_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = RUN;
                RUN:     if (w_limit_hit || w_halt_hit) w_state_nxt = DONE;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cycle    <= '0;
            r_instr    <= '0;
            r_stall    <= '0;
            r_branch   <= '0;
            r_memw     <= '0;
            r_halt_cnt <= '0;
            r_prev_pc  <= '0;
            r_halted   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev_pc <= PC;
            if (clear) begin
                r_cycle    <= '0;
                r_instr    <= '0;
                r_stall    <= '0;
                r_branch   <= '0;
                r_memw     <= '0;
                r_halt_cnt <= '0;
                r_halted   <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_run) begin
                    r_cycle    <= w_cycle_nxt;
                    r_instr    <= w_instr_nxt;
                    r_stall    <= w_stall_nxt;
                    r_branch   <= w_branch_nxt;
                    r_memw     <= w_memw_nxt;
                    r_halt_cnt <= w_halt_nxt;
                end else begin
                    r_halt_cnt <= '0;
                end
                if (w_halt_hit) r_halted <= 1'b1;
                if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_push_entry = '{dest: dest_in, data: write_data_in};
        w_push       = w_run && RegWrite_in && (dest_in != '0) && !clear;
        w_pop        = trace.trace_ready && !w_empty;
    end

    mips_trace_fifo #(
        .DEPTH   (TRACE_DEPTH),
        .entry_t (trace_entry_t)
    ) u_trace_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_flush (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        state_out            = r_state;
        done                 = (r_state == DONE);
        halted               = r_halted;
        cycle_cnt            = r_cycle;
        instr_cnt            = r_instr;
        stall_cnt            = r_stall;
        branch_taken_cnt     = r_branch;
        mem_write_cnt        = r_memw;
        trace.trace_valid    = !w_empty;
        trace.trace_data     = w_head;
        trace.trace_level    = w_level;
        trace.trace_overflow = r_overflow;
    end

endmodule

// File: tb/tb_mips_perf_monitor.sv
// Two monitors (4-bit unlimited, 32-bit with a 16-cycle limit) on shared stimulus vs a queue model.
module tb_mips_perf_monitor;
    import mips_mon_pkg::*;

    localparam int HALT_REPEAT = 4;
    localparam int DEPTH       = 8;

    logic        clock = 1'b0;
    logic        reset, start, clear, stall_in, Branch_in, Zero_in, MemWrite_in, RegWrite_in, ready;
    logic [9:0]  PC;
    logic [31:0] Instruction_in, write_data_in;
    logic [4:0]  dest_in;

    logic [1:0]  a_state, b_state;
    logic        a_done, b_done, a_halted, b_halted;
    logic [3:0]  a_cyc, a_ins, a_stl, a_br, a_mw;
    logic [31:0] b_cyc, b_ins, b_stl, b_br, b_mw;

    int n_checks = 0;
    int n_err    = 0;

    int          p_cntw [2] = '{4, 32};
    int          p_max  [2] = '{0, 16};
    int          m_state [2];
    longint      m_cyc [2], m_ins [2], m_stl [2], m_br [2], m_mw [2];
    int          m_hr [2];
    bit          m_halted [2], m_ovf [2];
    logic [9:0]  m_prev_pc [2];
    logic [36:0] m_fifo [2][$];
    logic [36:0] sb_q [2][$];

    mips_perf_monitor_if #(.TRACE_DEPTH(DEPTH)) tr_a ();
    mips_perf_monitor_if #(.TRACE_DEPTH(DEPTH)) tr_b ();
    assign tr_a.trace_ready = ready;
    assign tr_b.trace_ready = ready;

    mips_perf_monitor #(
        .CNT_W(4), .MAX_CYCLES(0), .TRACE_DEPTH(DEPTH), .HALT_REPEAT(HALT_REPEAT)
    ) u_dut_a (
        .clock(clock), .reset(reset), .start(start), .clear(clear), .PC(PC),
        .Instruction_in(Instruction_in), .stall_in(stall_in), .Branch_in(Branch_in),
        .Zero_in(Zero_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .dest_in(dest_in), .write_data_in(write_data_in), .state_out(a_state),
        .done(a_done), .halted(a_halted), .cycle_cnt(a_cyc), .instr_cnt(a_ins),
        .stall_cnt(a_stl), .branch_taken_cnt(a_br), .mem_write_cnt(a_mw), .trace(tr_a)
    );

    mips_perf_monitor #(
        .CNT_W(32), .MAX_CYCLES(16), .TRACE_DEPTH(DEPTH), .HALT_REPEAT(HALT_REPEAT)
    ) u_dut_b (
        .clock(clock), .reset(reset), .start(start), .clear(clear), .PC(PC),
        .Instruction_in(Instruction_in), .stall_in(stall_in), .Branch_in(Branch_in),
        .Zero_in(Zero_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .dest_in(dest_in), .write_data_in(write_data_in), .state_out(b_state),
        .done(b_done), .halted(b_halted), .cycle_cnt(b_cyc), .instr_cnt(b_ins),
        .stall_cnt(b_stl), .branch_taken_cnt(b_br), .mem_write_cnt(b_mw), .trace(tr_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sinc(input longint v, input bit en, input longint sat);
        return (en && v < sat) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0;  m_cyc[d] = 0;  m_ins[d] = 0;  m_stl[d] = 0;
            m_br[d] = 0;     m_mw[d] = 0;   m_hr[d] = 0;   m_halted[d] = 0;
            m_ovf[d] = 0;    m_prev_pc[d] = '0;
            m_fifo[d].delete();
            sb_q[d].delete();
        end
    endtask

    // One clock edge of the behavioural model, using the inputs seen at that edge.
    task automatic model_step(input int d);
        longint sat  = (longint'(1) << p_cntw[d]) - 1;
        bit     rep  = !stall_in && (PC == m_prev_pc[d]);
        bit     pop  = (m_fifo[d].size() != 0) && ready;
        bit     push = (m_state[d] == 1) && RegWrite_in && (dest_in != 0);
        bit     lim, hlt;
        m_prev_pc[d] = PC;
        if (clear) begin
            m_state[d] = 0;  m_cyc[d] = 0;  m_ins[d] = 0;  m_stl[d] = 0;
            m_br[d] = 0;     m_mw[d] = 0;   m_hr[d] = 0;   m_halted[d] = 0;
            m_ovf[d] = 0;
            m_fifo[d].delete();
            sb_q[d].delete();
        end else begin
            if (m_state[d] == 1) begin
                m_cyc[d] = sinc(m_cyc[d], 1'b1, sat);
                m_stl[d] = sinc(m_stl[d], stall_in, sat);
                m_ins[d] = sinc(m_ins[d], !stall_in && Instruction_in != 0, sat);
                m_br[d]  = sinc(m_br[d], Branch_in && Zero_in, sat);
                m_mw[d]  = sinc(m_mw[d], MemWrite_in, sat);
                m_hr[d]  = rep ? m_hr[d] + 1 : 0;
                lim = (p_max[d] != 0) && (m_cyc[d] == longint'(p_max[d]));
                hlt = (m_hr[d] == HALT_REPEAT - 1);
                if (lim || hlt) m_state[d] = 2;
                if (hlt) m_halted[d] = 1;
            end else begin
                m_hr[d] = 0;
                if (m_state[d] == 0 && start) m_state[d] = 1;
            end
            if (pop) void'(m_fifo[d].pop_front());
            if (push) begin
                if (m_fifo[d].size() < DEPTH) begin
                    m_fifo[d].push_back({dest_in, write_data_in});
                    sb_q[d].push_back({dest_in, write_data_in});
                end else begin
                    m_ovf[d] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_state", a_state, m_state[0]);       chk("b_state", b_state, m_state[1]);
        chk("a_done", a_done, m_state[0] == 2);    chk("b_done", b_done, m_state[1] == 2);
        chk("a_halted", a_halted, m_halted[0]);    chk("b_halted", b_halted, m_halted[1]);
        chk("a_cycle", a_cyc, m_cyc[0]);           chk("b_cycle", b_cyc, m_cyc[1]);
        chk("a_instr", a_ins, m_ins[0]);           chk("b_instr", b_ins, m_ins[1]);
        chk("a_stall", a_stl, m_stl[0]);           chk("b_stall", b_stl, m_stl[1]);
        chk("a_branch", a_br, m_br[0]);            chk("b_branch", b_br, m_br[1]);
        chk("a_memw", a_mw, m_mw[0]);              chk("b_memw", b_mw, m_mw[1]);
        chk("a_valid", tr_a.trace_valid, m_fifo[0].size() != 0);
        chk("b_valid", tr_b.trace_valid, m_fifo[1].size() != 0);
        chk("a_level", tr_a.trace_level, m_fifo[0].size());
        chk("b_level", tr_b.trace_level, m_fifo[1].size());
        chk("a_overflow", tr_a.trace_overflow, m_ovf[0]);
        chk("b_overflow", tr_b.trace_overflow, m_ovf[1]);
    endtask

    task automatic step();
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        start = 0;  clear = 0;  stall_in = 0;  Branch_in = 0;  Zero_in = 0;
        MemWrite_in = 0;  RegWrite_in = 0;  dest_in = '0;  write_data_in = '0;
        Instruction_in = '0;  ready = 0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic mon_pop(input int d, input logic [36:0] act);
        logic [36:0] exp;
        if (sb_q[d].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL trace_pop_%0d: got %0h, expected no entry (t=%0t)", d, act, $time);
        end else begin
            exp = sb_q[d].pop_front();
            chk(d == 0 ? "a_trace_data" : "b_trace_data", act, exp);
        end
    endtask

    // Decoupled drain monitor: inputs are stable at negedge, so a handshake seen here completes
    // on the next rising edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (tr_a.trace_valid && tr_a.trace_ready) mon_pop(0, tr_a.trace_data);
                if (tr_b.trace_valid && tr_b.trace_ready) mon_pop(1, tr_b.trace_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1;
        PC = '0;
        idle_inputs();
        model_reset();
        #12;
        check_all();
        chk("a_reset_data", tr_a.trace_data, 0);
        reset = 0;

        // Ten RUN cycles with a two-cycle stall.
        PC = 10'h100;  start = 1;
        step();
        start = 0;
        for (int i = 1; i <= 10; i++) begin
            PC = 10'(i * 4);  Instruction_in = 32'h2000_0000 + i;
            stall_in = (i == 3 || i == 4);
            step();
        end
        chk("t1_cycle", a_cyc, 10);   chk("t1_stall", a_stl, 2);
        chk("t1_instr", b_ins, 8);    chk("t1_state", b_state, 1);
        do_clear();

        // Cycle limit on the 16-cycle instance.
        PC = 10'h000;  start = 1;
        step();
        start = 0;
        for (int i = 1; i <= 21; i++) begin
            PC = 10'(i);  Instruction_in = 32'h1;
            step();
            if (i == 15) chk("t2_pre_limit", b_state, 1);
            if (i >= 16) chk("t2_frozen", b_cyc, 16);
        end
        chk("t2_done", b_done, 1);  chk("t2_halted", b_halted, 0);  chk("t2_sat", a_cyc, 15);
        do_clear();

        // Halt detection with PC stuck at 0x024.
        PC = 10'h020;  start = 1;
        step();
        start = 0;
        PC = 10'h024;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) chk("t3_still_run", a_state, 1);
        end
        chk("t3_done", a_state, 2);  chk("t3_halted", b_halted, 1);
        start = 1;
        step();
        chk("t3_start_ignored", a_state, 2);
        do_clear();
        chk("t3_clear_state", b_state, 0);  chk("t3_clear_cnt", b_cyc, 0);
        chk("t3_clear_halted", a_halted, 0);

        // Overflow on a full FIFO, then drain in order; $0 is never traced.
        PC = 10'h200;  start = 1;
        step();
        start = 0;
        for (int n = 1; n <= 9; n++) begin
            PC = 10'(10'h200 + n);  RegWrite_in = 1;  dest_in = 5'(n);
            write_data_in = 32'h100 + n;
            step();
        end
        PC = 10'h2F0;  dest_in = 5'd0;  write_data_in = 32'hBAD;
        step();
        chk("t4_level", tr_a.trace_level, 8);  chk("t4_overflow", tr_b.trace_overflow, 1);
        RegWrite_in = 0;  ready = 1;
        repeat (9) step();
        chk("t4_drained", tr_a.trace_level, 0);
        chk("t4_hold_data", tr_a.trace_data, {5'd8, 32'h108});
        do_clear();

        // Full FIFO with simultaneous push and pop.
        PC = 10'h300;  start = 1;
        step();
        start = 0;
        for (int n = 1; n <= 8; n++) begin
            PC = 10'(10'h300 + n);  RegWrite_in = 1;  dest_in = 5'(n);
            write_data_in = 32'h200 + n;
            step();
        end
        PC = 10'h310;  dest_in = 5'd5;  write_data_in = 32'hDEAD;  ready = 1;
        step();
        chk("t5_level", tr_b.trace_level, 8);  chk("t5_no_overflow", tr_a.trace_overflow, 0);
        RegWrite_in = 0;
        repeat (9) step();
        chk("t5_last", tr_b.trace_data, {5'd5, 32'hDEAD});
        do_clear();

        // Saturation of the 4-bit counters, then asynchronous reset mid-run.
        PC = 10'h000;  start = 1;
        step();
        start = 0;
        for (int i = 1; i <= 20; i++) begin
            PC = 10'(i);  stall_in = 1;
            RegWrite_in = (i <= 3);  dest_in = 5'(i);  write_data_in = 32'h300 + i;
            step();
        end
        chk("t6_sat_stall", a_stl, 15);  chk("t6_b_stall", b_stl, 16);
        reset = 1;
        #1;
        chk("t6_rst_state", a_state, 0);    chk("t6_rst_stall", a_stl, 0);
        chk("t6_rst_cycle", b_cyc, 0);      chk("t6_rst_done", b_done, 0);
        chk("t6_rst_valid", tr_a.trace_valid, 0);
        chk("t6_rst_data", tr_a.trace_data, 0);
        model_reset();
        #2;
        reset = 0;
        idle_inputs();

        // Randomised run against the model.
        for (int i = 0; i < 400; i++) begin
            start          = ($urandom_range(7) == 0);
            clear          = ($urandom_range(49) == 0);
            stall_in       = ($urandom_range(3) == 0);
            if ($urandom_range(2) != 0) PC = 10'($urandom);
            Instruction_in = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            Branch_in      = 1'($urandom);
            Zero_in        = 1'($urandom);
            MemWrite_in    = 1'($urandom);
            RegWrite_in    = 1'($urandom);
            dest_in        = 5'($urandom);
            write_data_in  = $urandom;
            ready          = ($urandom_range(2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
